mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Sits directly downstream of the EX/MEM pipeline register.
- Consumes the registered load/store, address, store data and instruction, and drives a valid/grant data-memory port.
- Holds the pipeline through a stall while an access is outstanding.
- Presents a registered MEM/WB bundle: sign/zero-extended load data, ALU result, mem_reg select, link address, instruction.

Parameters:
- NOP_INSN, 32'h00000013, instruction written to MEM/WB when a bubble is inserted.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load_in  in  1  EX/MEM load flag
- store_in  in  1  EX/MEM store flag
- alu_res_in  in  32  effective address / ALU result
- opb_data_in  in  32  store data (rs2)
- mem_reg_in  in  2  writeback source select, passed through
- next_sel_addr_in  in  32  PC+4 link value, passed through
- pre_address_in  in  32  instruction PC, passed through
- instruction_in  in  32  instruction; funct3 = [14:12]
- stall  out  1  hold EX/MEM and all upstream stages
- misalign  out  1  one-cycle pulse, misaligned access dropped
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address {alu_res_in[31:2],2'b00}
- mem_wdata  out  32  store data shifted to byte lanes
- mem_mask  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word
- load_data_out  out  32  extended load result
- alu_res_out, mem_reg_out, next_sel_address_out, pre_address_out, instruction_out  out  32/2/32/32/32  MEM/WB copies

Behaviour:
- Reset (async, any state): FSM=IDLE; mem_req=0; mem_we=0; misalign=0; all MEM/WB outputs 0, except instruction_out=NOP_INSN. Any in-flight access is abandoned; late mem_gnt/mem_rvalid ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Aligned load or store present: go to REQ. stall=1 combinationally this cycle.
  - Neither load nor store: no state change; MEM/WB captures inputs every edge; load_data_out=0.
- REQ:
  - mem_req=1; mem_addr/mem_we/mem_wdata/mem_mask held stable until mem_gnt.
  - mem_gnt=1 on a store: go to DONE.
  - mem_gnt=1 on a load: go to WAIT. If mem_rvalid is also 1 in the same cycle, capture data and go directly to DONE.
  - stall=1.
- WAIT: mem_req=0; on mem_rvalid, capture extended data into a holding register and go to DONE. stall=1.
- DONE:
  - stall=0; MEM/WB captures inputs plus held load data on this edge; go to IDLE.
  - The EX/MEM register advances on the same edge, so the same access is never reissued.
- Alignment (DONE-cycle access is always aligned):
  - LH/LHU/SH misaligned when addr[0]=1.
  - LW/SW misaligned when addr[1:0]!=0.
  - Misaligned access: no memory request; misalign=1 for one cycle; stall=0; MEM/WB takes a bubble: instruction_out=NOP_INSN, mem_reg_out=0, load_data_out=0.
- Store lanes:
  - SB: mask=4'b0001<<addr[1:0], wdata={4{opb[7:0]}}.
  - SH: mask=4'b0011<<addr[1:0], wdata={2{opb[15:0]}}.
  - SW: mask=4'b1111, wdata=opb.
- Load extract by funct3, byte selected by addr[1:0]:
  - 000 LB sign-extend.
  - 001 LH sign-extend.
  - 010 LW.
  - 100 LBU zero-extend.
  - 101 LHU zero-extend.
  - Other funct3 values treated as LW.
- Loads: mem_mask=4'b1111, mem_we=0.
- Latency: minimum 3 cycles from load/store arrival to MEM/WB update with zero-wait memory (IDLE, REQ with gnt+rvalid, DONE). Non-memory instructions: 1 cycle.
- load_in and store_in both set: treated as a store.

Test Plan:
- ALU op, load=store=0, alu_res=0x1234 -> stall never asserted, next edge alu_res_out=0x1234, load_data_out=0.
- SB addr=0x1003 opb=0xAABBCCDD -> mem_req=1, mem_we=1, mask=4'b1000, wdata=0xDDDDDDDD; gnt after 2 cycles -> stall drops in DONE, one request accepted only.
- LB addr=0x2002, rdata=0x00800000, rvalid 3 cycles after gnt -> load_data_out=0xFFFFFF80. Same with LBU -> 0x00000080.
- LW addr=0x3000 with gnt and rvalid both high in REQ -> DONE next cycle, load_data_out=rdata, total 3 cycles.
- LW addr=0x3002 -> no mem_req, misalign pulse 1 cycle, instruction_out=0x00000013, mem_reg_out=0.
- rst asserted during WAIT, rvalid arrives after release -> mem_req=0, stall=0, outputs at reset values, stray rvalid ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between the EX/MEM and MEM/WB registers.
// Issues one valid/grant data-memory access per load/store and stalls the
// upstream pipeline while it is outstanding. Misaligned accesses are dropped
// and replaced with a bubble. Returned load data is byte-selected and
// sign/zero-extended before it is registered into the MEM/WB bundle.
module mem_access_stage #(
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] opb_data_in,
  input  logic [1:0]  mem_reg_in,
  input  logic [31:0] next_sel_addr_in,
  input  logic [31:0] pre_address_in,
  input  logic [31:0] instruction_in,
  output logic        stall,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data_out,
  output logic [31:0] alu_res_out,
  output logic [1:0]  mem_reg_out,
  output logic [31:0] next_sel_address_out,
  output logic [31:0] pre_address_out,
  output logic [31:0] instruction_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [1:0]  mem_reg_q, mem_reg_d;
  logic [31:0] next_sel_q, next_sel_d;
  logic [31:0] pre_addr_q, pre_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] load_data_q, load_data_d;

  logic [2:0]  funct3;
  logic [1:0]  byte_off;
  logic        is_mem;
  logic        is_store;
  logic        is_load;
  logic        size_half;
  logic        size_word;
  logic        misaligned;

  logic [3:0]  store_mask;
  logic [31:0] store_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  logic        wb_en;
  logic        wb_bubble;
  logic [31:0] wb_load;
  logic        stall_c;
  logic        misalign_c;
  logic        mem_req_c;
  logic        mem_we_c;

  // A load with the store flag also set is handled as a store.
  assign funct3    = instruction_in[14:12];
  assign byte_off  = alu_res_in[1:0];
  assign is_mem    = load_in | store_in;
  assign is_store  = store_in;
  assign is_load   = load_in & ~store_in;
  // funct3[1:0]: 00 byte, 01 half, anything with bit 1 set is a word.
  assign size_half = (funct3[1:0] == 2'b01);
  assign size_word = funct3[1];
  assign misaligned = is_mem & ((size_half & byte_off[0]) |
                                (size_word & (byte_off != 2'b00)));

  // Replicate store data across byte lanes and build the matching byte enables.
  always_comb begin
    store_mask  = 4'b1111;
    store_wdata = opb_data_in;
    if (size_word) begin
      store_mask  = 4'b1111;
      store_wdata = opb_data_in;
    end else if (size_half) begin
      store_mask  = 4'b0011 << byte_off;
      store_wdata = {2{opb_data_in[15:0]}};
    end else begin
      store_mask  = 4'b0001 << byte_off;
      store_wdata = {4{opb_data_in[7:0]}};
    end
  end

  // Pick the addressed byte/half of the returned word and extend it by funct3.
  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (byte_off)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'b0, rd_byte};
      3'b101:  load_ext = {16'b0, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Access FSM: next state, handshake outputs, stall and MEM/WB load enable.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    wb_en      = 1'b0;
    wb_bubble  = 1'b0;
    wb_load    = 32'b0;
    case (state_q)
      IDLE: begin
        if (is_mem && !misaligned) begin
          stall_c = 1'b1;
          state_d = REQ;
        end else if (is_mem) begin
          misalign_c = 1'b1;
          wb_en      = 1'b1;
          wb_bubble  = 1'b1;
        end else begin
          wb_en = 1'b1;
        end
      end
      REQ: begin
        stall_c   = 1'b1;
        mem_req_c = 1'b1;
        mem_we_c  = is_store;
        if (mem_gnt) begin
          if (is_store) begin
            state_d = DONE;
          end else if (mem_rvalid) begin
            hold_d  = load_ext;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (mem_rvalid) begin
          hold_d  = load_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_en   = 1'b1;
        wb_load = is_load ? hold_q : 32'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // MEM/WB bundle: load on any non-stalled edge, substituting a bubble if needed.
  always_comb begin
    alu_res_d   = alu_res_q;
    mem_reg_d   = mem_reg_q;
    next_sel_d  = next_sel_q;
    pre_addr_d  = pre_addr_q;
    instr_d     = instr_q;
    load_data_d = load_data_q;
    if (wb_en) begin
      alu_res_d   = alu_res_in;
      next_sel_d  = next_sel_addr_in;
      pre_addr_d  = pre_address_in;
      mem_reg_d   = wb_bubble ? 2'b00 : mem_reg_in;
      instr_d     = wb_bubble ? NOP_INSN : instruction_in;
      load_data_d = wb_bubble ? 32'b0 : wb_load;
    end
  end

  // State, load holding register and MEM/WB registers; reset abandons any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= 32'b0;
      alu_res_q   <= 32'b0;
      mem_reg_q   <= 2'b00;
      next_sel_q  <= 32'b0;
      pre_addr_q  <= 32'b0;
      instr_q     <= NOP_INSN;
      load_data_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      alu_res_q   <= alu_res_d;
      mem_reg_q   <= mem_reg_d;
      next_sel_q  <= next_sel_d;
      pre_addr_q  <= pre_addr_d;
      instr_q     <= instr_d;
      load_data_q <= load_data_d;
    end
  end

  assign stall     = stall_c;
  assign misalign  = misalign_c;
  assign mem_req   = mem_req_c;
  assign mem_we    = mem_we_c;
  assign mem_addr  = {alu_res_in[31:2], 2'b00};
  assign mem_wdata = store_wdata;
  assign mem_mask  = is_store ? store_mask : 4'b1111;

  assign load_data_out        = load_data_q;
  assign alu_res_out          = alu_res_q;
  assign mem_reg_out          = mem_reg_q;
  assign next_sel_address_out = next_sel_q;
  assign pre_address_out      = pre_addr_q;
  assign instruction_out      = instr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven vectors with a scoreboard queue, a small
// memory responder with programmable grant/rvalid delays, and a hand-written
// reset-during-WAIT sequence.
module tb_mem_access_stage;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int          MAXC = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_in, store_in;
  logic [31:0] alu_res_in, opb_data_in, next_sel_addr_in, pre_address_in, instruction_in;
  logic [1:0]  mem_reg_in;
  logic        stall, misalign, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] load_data_out, alu_res_out, next_sel_address_out, pre_address_out, instruction_out;
  logic [1:0]  mem_reg_out;

  int checks = 0;
  int passes = 0;
  int seq_idx = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.NOP_INSN(NOP)) dut (
    .clk(clk), .rst(rst),
    .load_in(load_in), .store_in(store_in),
    .alu_res_in(alu_res_in), .opb_data_in(opb_data_in),
    .mem_reg_in(mem_reg_in), .next_sel_addr_in(next_sel_addr_in),
    .pre_address_in(pre_address_in), .instruction_in(instruction_in),
    .stall(stall), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .load_data_out(load_data_out), .alu_res_out(alu_res_out),
    .mem_reg_out(mem_reg_out), .next_sel_address_out(next_sel_address_out),
    .pre_address_out(pre_address_out), .instruction_out(instruction_out)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] opb;
    logic [31:0] rdata;
    logic [1:0]  mreg;
    int          gd;
    int          rd;
    int          lat;
    logic        mis;
    logic        req;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] ld_data;
    logic [31:0] insn;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] opb,
                              input logic [31:0] rdata, input logic [1:0] mreg,
                              input int gd, input int rd, input int lat, input logic mis,
                              input logic [3:0] mask, input logic [31:0] wdata,
                              input logic [31:0] ld_data);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.opb = opb; v.rdata = rdata;
    v.mreg = mreg; v.gd = gd; v.rd = rd; v.lat = lat; v.mis = mis;
    v.req = (ld | st) & ~mis;
    v.mask = mask; v.wdata = wdata; v.ld_data = ld_data;
    v.insn = 32'b0; v.pc = 32'b0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drive one EX/MEM record on the falling edge and queue its expectation.
  task automatic applyStimulus(input vec_t v_in);
    vec_t v;
    logic [6:0] opc;
    v = v_in;
    @(negedge clk);
    opc = v.st ? 7'h23 : (v.ld ? 7'h03 : 7'h33);
    v.insn = {17'h0, v.f3, 5'd5, opc};
    v.pc = 32'h0000_0100 + 32'(seq_idx * 8);
    seq_idx++;
    load_in          = v.ld;
    store_in         = v.st;
    alu_res_in       = v.addr;
    opb_data_in      = v.opb;
    mem_reg_in       = v.mreg;
    pre_address_in   = v.pc;
    next_sel_addr_in = v.pc + 32'd4;
    instruction_in   = v.insn;
    mem_gnt          = 1'b0;
    mem_rvalid       = 1'b0;
    sbq.push_back(v);
  endtask

  // Memory responder: one loop iteration per clock, until the DUT releases stall.
  task automatic serviceMemory(input vec_t v, output int cyc, output logic first_mis,
                               output logic first_stall, output logic saw_req, output int gnt_cnt);
    int   req_cnt, wait_cnt;
    logic granted, got, stall_now, done;
    cyc = 0; req_cnt = 0; wait_cnt = 0; gnt_cnt = 0;
    granted = 0; got = 0; done = 0; saw_req = 0;
    first_mis = 1'b0; first_stall = 1'b0;
    while (!done && cyc < MAXC) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h5A5A_5A5A;
      #1;
      if (cyc == 0) begin
        first_mis   = misalign;
        first_stall = stall;
      end
      if (mem_req) begin
        saw_req = 1'b1;
        checkOutput("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        checkOutput("mem_we/mask", {27'b0, mem_we, mem_mask}, {27'b0, v.st, v.mask});
        if (v.st) checkOutput("mem_wdata", mem_wdata, v.wdata);
        if (req_cnt >= v.gd) begin
          mem_gnt = 1'b1;
          gnt_cnt++;
          granted = 1'b1;
          if (v.ld && !v.st && v.rd == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            got = 1'b1;
          end
        end
        req_cnt++;
      end else if (granted && !got && v.ld && !v.st) begin
        wait_cnt++;
        if (wait_cnt >= v.rd) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
          got = 1'b1;
        end
      end
      #1;
      stall_now = stall;
      @(posedge clk);
      cyc++;
      if (!stall_now) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      $display("[TB] FAIL stall_timeout: stall still high after %0d cycles, required release", cyc);
    end
  endtask

  // Pop the oldest expectation and compare it against the MEM/WB bundle.
  task automatic popAndCompare(input int cyc, input logic first_mis, input logic first_stall,
                               input logic saw_req, input int gnt_cnt);
    vec_t e;
    if (sbq.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sbq.pop_front();
    checkOutput("latency", 32'(cyc), 32'(e.lat));
    checkOutput("first_stall", {31'b0, first_stall}, {31'b0, e.req});
    checkOutput("misalign", {31'b0, first_mis}, {31'b0, e.mis});
    checkOutput("saw_req", {31'b0, saw_req}, {31'b0, e.req});
    checkOutput("grants", 32'(gnt_cnt), e.req ? 32'd1 : 32'd0);
    checkOutput("load_data_out", load_data_out, e.ld_data);
    checkOutput("instruction_out", instruction_out, e.mis ? NOP : e.insn);
    checkOutput("mem_reg_out", {30'b0, mem_reg_out}, e.mis ? 32'd0 : {30'b0, e.mreg});
    if (!e.mis) begin
      checkOutput("alu_res_out", alu_res_out, e.addr);
      checkOutput("pre_address_out", pre_address_out, e.pc);
      checkOutput("next_sel_address_out", next_sel_address_out, e.pc + 32'd4);
    end
  endtask

  task automatic runVector(input vec_t v);
    int   cyc, gnt_cnt;
    logic fm, fs, sr;
    applyStimulus(v);
    serviceMemory(v, cyc, fm, fs, sr, gnt_cnt);
    #1;
    popAndCompare(cyc, fm, fs, sr, gnt_cnt);
  endtask

  initial begin
    //            ld st f3      addr          opb           rdata         mreg gd rd lat mis mask     wdata         ld_data
    vecs.push_back(mk(0, 0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        2'd0, 0, 0, 1, 0, 4'b1111, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_1003, 32'hAABBCCDD, 32'h0,        2'd3, 2, 0, 5, 0, 4'b1000, 32'hDDDDDDDD, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_2002, 32'h0,        32'h0080_0000, 2'd1, 0, 3, 6, 0, 4'b1111, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_2002, 32'h0,        32'h0080_0000, 2'd1, 0, 3, 6, 0, 4'b1111, 32'h0,        32'h0000_0080));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_3000, 32'h0,        32'hCAFEBABE, 2'd1, 0, 0, 3, 0, 4'b1111, 32'h0,        32'hCAFEBABE));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_3002, 32'h0,        32'h0,        2'd1, 0, 0, 1, 1, 4'b1111, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_4002, 32'h0,        32'h8001_1234, 2'd1, 1, 1, 5, 0, 4'b1111, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_4000, 32'h0,        32'h8001_F234, 2'd1, 0, 2, 5, 0, 4'b1111, 32'h0,        32'h0000_F234));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_5002, 32'h1111BEEF, 32'h0,        2'd3, 0, 0, 3, 0, 4'b1100, 32'hBEEFBEEF, 32'h0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_6000, 32'h12345678, 32'h0,        2'd3, 1, 0, 4, 0, 4'b1111, 32'h12345678, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_5001, 32'h1111BEEF, 32'h0,        2'd3, 0, 0, 1, 1, 4'b1111, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 3'b000, 32'h0000_7001, 32'h0000_0055, 32'h0,       2'd3, 0, 0, 3, 0, 4'b0010, 32'h55555555, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_8001, 32'h0,        32'h0000_7F00, 2'd1, 0, 0, 3, 0, 4'b1111, 32'h0,        32'h0000_007F));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_6001, 32'h12345678, 32'h0,        2'd3, 0, 0, 1, 1, 4'b1111, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_9003, 32'h0,        32'hFE00_0000, 2'd1, 0, 1, 4, 0, 4'b1111, 32'h0,        32'h0000_00FE));
    vecs.push_back(mk(1, 0, 3'b111, 32'h0000_3004, 32'h0,        32'h89ABCDEF, 2'd1, 0, 0, 3, 0, 4'b1111, 32'h0,        32'h89ABCDEF));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_4001, 32'h0,        32'h0,        2'd1, 0, 0, 1, 1, 4'b1111, 32'h0,        32'h0));

    rst = 1'b1;
    load_in = 1'b0; store_in = 1'b0; alu_res_in = 32'h0; opb_data_in = 32'h0;
    mem_reg_in = 2'd0; next_sel_addr_in = 32'h0; pre_address_in = 32'h0;
    instruction_in = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst instruction_out", instruction_out, NOP);
    checkOutput("rst alu_res_out", alu_res_out, 32'h0);
    checkOutput("rst load_data_out", load_data_out, 32'h0);
    checkOutput("rst mem_reg_out", {30'b0, mem_reg_out}, 32'h0);
    checkOutput("rst req/we/mis/stall", {28'b0, mem_req, mem_we, misalign, stall}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) runVector(vecs[i]);

    // Reset while a load is parked in WAIT, then a stray rvalid afterwards.
    @(negedge clk);
    load_in = 1'b1; store_in = 1'b0; alu_res_in = 32'h0000_3000;
    instruction_in = {17'h0, 3'b010, 5'd5, 7'h03}; mem_reg_in = 2'd1;
    #1;
    checkOutput("wr idle stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("wr req", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    checkOutput("wr wait req/stall", {30'b0, mem_req, stall}, 32'b01);
    #2;
    rst = 1'b1;
    load_in = 1'b0; store_in = 1'b0; alu_res_in = 32'h0; mem_reg_in = 2'd0;
    instruction_in = 32'h0000_0033;
    #1;
    checkOutput("wr rst req/stall", {30'b0, mem_req, stall}, 32'b00);
    checkOutput("wr rst instruction_out", instruction_out, NOP);
    checkOutput("wr rst load_data_out", load_data_out, 32'h0);
    checkOutput("wr rst alu_res_out", alu_res_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    checkOutput("stray rvalid req/stall", {30'b0, mem_req, stall}, 32'b00);
    checkOutput("stray rvalid load_data_out", load_data_out, 32'h0);
    checkOutput("stray rvalid instruction_out", instruction_out, 32'h0000_0033);
    @(negedge clk);
    mem_rvalid = 1'b0;

    runVector(mk(1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h1357_9BDF, 2'd1, 0, 0, 3, 0, 4'b1111, 32'h0, 32'h1357_9BDF));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
